// File: rtl/lcd_bus_sequencer.sv
// HD44780 4-bit bus owner: power-on init, then two-port byte writer.
// Tie policy: LCD_ARB_RR_EN selects round-robin, else port A wins ties.
module lcd_bus_sequencer #(
  parameter int CLK_MHZ  = 12,
  parameter int E_CYCLES = 6,
  parameter int SHORT_US = 40,
  parameter int LONG_US  = 1640,
  parameter int PWRUP_US = 15000
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic       a_rs,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic       b_rs,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic [3:0] lcd_dq,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic       init_done,
  output logic       busy
);

  localparam int CW = 16;
  localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam int EW = (E_CYCLES > 1) ? $clog2(E_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_SETUP_HI,
    S_E_HI,
    S_HOLD_HI,
    S_SETUP_LO,
    S_E_LO,
    S_HOLD_LO,
    S_WAIT
  } state_t;

  state_t          state;
  logic [PW-1:0]   psc;
  logic            tick;
  logic [CW-1:0]   cnt;
  logic [EW-1:0]   ecnt;
  logic [2:0]      step;
  logic            armed;
  logic [7:0]      hold_data;
  logic            hold_rs;
  logic            single;
  logic [7:0]      init_b;
  logic            grant_a;
  logic            grant_b;
  logic            sel_rs;
  logic [7:0]      sel_data;
  logic            idle_st;

  assign tick    = (psc == PW'(CLK_MHZ - 1));
  assign idle_st = (state == S_IDLE);

`ifdef LCD_ARB_RR_EN
  logic last_b;

  // remember the last winner so the next tie goes to the other port
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      last_b <= 1'b1;
    else if (a_ready | b_ready)
      last_b <= b_ready;
  end

  assign grant_a = a_valid & (~b_valid | last_b);
  assign grant_b = b_valid & (~a_valid | ~last_b);
`else
  assign grant_a = a_valid;
  assign grant_b = b_valid & ~a_valid;
`endif

  assign a_ready  = idle_st & grant_a;
  assign b_ready  = idle_st & grant_b;
  assign sel_rs   = grant_a ? a_rs : b_rs;
  assign sel_data = grant_a ? a_data : b_data;

  // init script: four wake-up nibbles then four config bytes
  always_comb begin
    init_b = 8'h06;
    unique case (step)
      3'd0, 3'd1, 3'd2: init_b = 8'h30;
      3'd3:             init_b = 8'h20;
      3'd4:             init_b = 8'h28;
      3'd5:             init_b = 8'h0C;
      3'd6:             init_b = 8'h01;
      default:          init_b = 8'h06;
    endcase
  end

  // counter load is N+1 so the wait is never shorter than N us
  function automatic logic [CW-1:0] wait_len(
    input logic       in_init,
    input logic [2:0] s,
    input logic       rs,
    input logic [7:0] d
  );
    logic slow;
    slow = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    if (in_init && s == 3'd0) return CW'(4100 + 1);
    if (in_init && s == 3'd1) return CW'(100 + 1);
    if (slow) return CW'(LONG_US + 1);
    return CW'(SHORT_US + 1);
  endfunction

  // free-running 1us prescaler
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      psc <= '0;
    else if (tick)
      psc <= '0;
    else
      psc <= psc + PW'(1);
  end

  // bus sequencer: init script, arbitration, nibble strobes, delays
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PWRUP;
      armed     <= 1'b0;
      cnt       <= '0;
      ecnt      <= '0;
      step      <= '0;
      hold_data <= '0;
      hold_rs   <= 1'b0;
      single    <= 1'b0;
      lcd_dq    <= '0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      unique case (state)
        S_PWRUP: begin
          if (!armed) begin
            cnt   <= CW'(PWRUP_US + 1);
            armed <= 1'b1;
          end else if (cnt == '0) begin
            step  <= '0;
            state <= S_INIT;
          end else if (tick) begin
            cnt <= cnt - CW'(1);
          end
        end
        S_INIT: begin
          hold_data <= init_b;
          hold_rs   <= 1'b0;
          single    <= ~step[2];
          lcd_dq    <= init_b[7:4];
          lcd_rs    <= 1'b0;
          state     <= S_SETUP_HI;
        end
        S_IDLE: begin
          if (grant_a | grant_b) begin
            hold_data <= sel_data;
            hold_rs   <= sel_rs;
            single    <= 1'b0;
            lcd_dq    <= sel_data[7:4];
            lcd_rs    <= sel_rs;
            busy      <= 1'b1;
            state     <= S_SETUP_HI;
          end
        end
        S_SETUP_HI: begin
          lcd_e <= 1'b1;
          ecnt  <= '0;
          state <= S_E_HI;
        end
        S_E_HI: begin
          if (ecnt == EW'(E_CYCLES - 1)) begin
            lcd_e <= 1'b0;
            state <= S_HOLD_HI;
          end else begin
            ecnt <= ecnt + EW'(1);
          end
        end
        S_HOLD_HI: begin
          if (single) begin
            cnt   <= wait_len(~init_done, step,
                              hold_rs, hold_data);
            state <= S_WAIT;
          end else begin
            lcd_dq <= hold_data[3:0];
            state  <= S_SETUP_LO;
          end
        end
        S_SETUP_LO: begin
          lcd_e <= 1'b1;
          ecnt  <= '0;
          state <= S_E_LO;
        end
        S_E_LO: begin
          if (ecnt == EW'(E_CYCLES - 1)) begin
            lcd_e <= 1'b0;
            state <= S_HOLD_LO;
          end else begin
            ecnt <= ecnt + EW'(1);
          end
        end
        S_HOLD_LO: begin
          cnt   <= wait_len(~init_done, step,
                            hold_rs, hold_data);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (init_done) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (step == 3'd7) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              step  <= step + 3'd1;
              state <= S_INIT;
            end
          end else if (tick) begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with shortened timings.
// Expected strobe sequences and delay windows are hand-derived.
`timescale 1ns/1ps
module tb_lcd_bus_sequencer;

  localparam int CLK_MHZ  = 2;
  localparam int E_CYCLES = 6;
  localparam int SHORT_US = 40;
  localparam int LONG_US  = 200;
  localparam int PWRUP_US = 1000;
  localparam int US       = CLK_MHZ;

  localparam logic [4:0] EXP_INIT [12] = '{
    5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
    5'h00, 5'h0C, 5'h00, 5'h01, 5'h00, 5'h06
  };

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic       a_rs = 1'b0;
  logic [7:0] a_data = '0;
  logic       b_valid = 1'b0;
  logic       b_rs = 1'b0;
  logic [7:0] b_data = '0;
  logic       a_ready;
  logic       b_ready;
  logic [3:0] lcd_dq;
  logic       lcd_rs;
  logic       lcd_e;
  logic       init_done;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stable_err = 0;
  logic [4:0] nib_q[$];
  int rise_q[$];
  int fall_q[$];
  int width_q[$];

  lcd_bus_sequencer #(
    .CLK_MHZ (CLK_MHZ),
    .E_CYCLES(E_CYCLES),
    .SHORT_US(SHORT_US),
    .LONG_US (LONG_US),
    .PWRUP_US(PWRUP_US)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_rs     (a_rs),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_rs     (b_rs),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .lcd_dq   (lcd_dq),
    .lcd_rs   (lcd_rs),
    .lcd_e    (lcd_e),
    .init_done(init_done),
    .busy     (busy)
  );

  initial forever #5 refclk = ~refclk;

  initial forever begin
    @(posedge refclk);
    cyc++;
  end

  // strobe logger: nibble/rs at E rise, width, stability
  initial begin
    logic e_prev;
    logic [4:0] cur;
    int w;
    e_prev = 1'b0;
    cur = '0;
    w = 0;
    forever begin
      @(negedge refclk);
      if (lcd_e && !e_prev) begin
        cur = {lcd_rs, lcd_dq};
        nib_q.push_back(cur);
        rise_q.push_back(cyc);
        w = 1;
      end else if (lcd_e) begin
        w++;
        if ({lcd_rs, lcd_dq} !== cur) stable_err++;
      end else if (e_prev) begin
        fall_q.push_back(cyc);
        width_q.push_back(w);
      end
      e_prev = lcd_e;
    end
  end

  task automatic clear_log();
    nib_q.delete();
    rise_q.delete();
    fall_q.delete();
    width_q.delete();
    stable_err = 0;
  endtask

  task automatic send(input bit port_b, input logic rs,
                      input logic [7:0] d, input int budget,
                      output int acc, output bit ok,
                      output logic late);
    ok = 1'b0;
    acc = 0;
    late = 1'b0;
    if (port_b) begin
      b_valid = 1'b1; b_rs = rs; b_data = d;
    end else begin
      a_valid = 1'b1; a_rs = rs; a_data = d;
    end
    for (int n = 0; n < budget && !ok; n++) begin
      #1;
      if ((port_b ? b_ready : a_ready) === 1'b1) begin
        ok = 1'b1;
        acc = cyc;
      end
      @(negedge refclk);
    end
    #1;
    late = port_b ? b_ready : a_ready;
    if (port_b) b_valid = 1'b0;
    else a_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok,
                           output int at);
    ok = 1'b0;
    at = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge refclk);
      #1;
      if (busy === 1'b0) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic wait_init(input int budget, output bit ok,
                           output int at);
    ok = 1'b0;
    at = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge refclk);
      if (init_done === 1'b1) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic test_reset();
    int t0;
    int dt;
    bit ok;
    rst_n = 1'b0;
    repeat (3) @(negedge refclk);
    #1;
    checks++;
    if (lcd_e !== 1'b0)
      $display("FAIL rst_e got %b want 0", lcd_e);
    if (lcd_e !== 1'b0) failures++;
    checks++;
    if (lcd_dq !== 4'h0 || lcd_rs !== 1'b0) begin
      $display("FAIL rst_bus got dq=%h rs=%b want 0/0",
               lcd_dq, lcd_rs);
      failures++;
    end
    checks++;
    if (init_done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL rst_flags got done=%b busy=%b want 0/1",
               init_done, busy);
      failures++;
    end
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      $display("FAIL rst_ready got %b%b want 00",
               a_ready, b_ready);
      failures++;
    end
    clear_log();
    @(negedge refclk);
    rst_n = 1'b1;
    t0 = cyc;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge refclk);
      if (lcd_e === 1'b1) ok = 1'b1;
    end
    dt = cyc - t0;
    checks++;
    if (!ok || dt < PWRUP_US * US || dt > PWRUP_US * US + 10) begin
      $display("FAIL pwrup_delay got %0d cycles want %0d..%0d",
               dt, PWRUP_US * US, PWRUP_US * US + 10);
      failures++;
    end
  endtask

  task automatic test_init();
    bit ok;
    int at;
    int gap;
    int dt;
    wait_init(20000, ok, at);
    checks++;
    if (!ok) begin
      $display("FAIL init_timeout got done=%b want 1", init_done);
      failures++;
    end
    checks++;
    if (nib_q.size() != 12) begin
      $display("FAIL init_count got %0d want 12", nib_q.size());
      failures++;
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (nib_q[i] !== EXP_INIT[i] || width_q[i] != E_CYCLES) begin
          $display("FAIL init_nib%0d got %h/w%0d want %h/w%0d",
                   i, nib_q[i], width_q[i], EXP_INIT[i], E_CYCLES);
          failures++;
        end
      end
      gap = rise_q[1] - fall_q[0];
      checks++;
      if (gap < 4100 * US || gap > 4100 * US + 15) begin
        $display("FAIL init_gap1 got %0d want %0d..%0d",
                 gap, 4100 * US, 4100 * US + 15);
        failures++;
      end
      dt = at - fall_q[11];
      checks++;
      if (dt < SHORT_US * US || dt > SHORT_US * US + 10) begin
        $display("FAIL init_done_delay got %0d want %0d..%0d",
                 dt, SHORT_US * US, SHORT_US * US + 10);
        failures++;
      end
    end
    checks++;
    if (stable_err != 0) begin
      $display("FAIL init_stable got %0d want 0", stable_err);
      failures++;
    end
  endtask

  task automatic test_data_write();
    int acc1, acc2, tid, dt;
    bit ok1, ok2, ok3;
    logic late1, late2;
    @(negedge refclk);
    clear_log();
    send(1'b0, 1'b1, 8'h41, 100, acc1, ok1, late1);
    checks++;
    if (!ok1 || late1 !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL data_accept got ok=%0d late=%b busy=%b want 1/0/1",
               ok1, late1, busy);
      failures++;
    end
    send(1'b0, 1'b1, 8'h42, 500, acc2, ok2, late2);
    wait_idle(500, ok3, tid);
    checks++;
    if (!ok2 || !ok3 || nib_q.size() != 4) begin
      $display("FAIL data_count got ok=%0d%0d n=%0d want 11/4",
               ok2, ok3, nib_q.size());
      failures++;
    end else begin
      checks++;
      if (nib_q[0] !== 5'h14 || nib_q[1] !== 5'h11) begin
        $display("FAIL data_nibs got %h %h want 14 11",
                 nib_q[0], nib_q[1]);
        failures++;
      end
      checks++;
      if (width_q[0] != E_CYCLES || width_q[1] != E_CYCLES) begin
        $display("FAIL data_ewidth got %0d %0d want %0d",
                 width_q[0], width_q[1], E_CYCLES);
        failures++;
      end
      dt = acc2 - fall_q[1];
      checks++;
      if (dt < SHORT_US * US || dt > SHORT_US * US + 10) begin
        $display("FAIL data_short_wait got %0d want %0d..%0d",
                 dt, SHORT_US * US, SHORT_US * US + 10);
        failures++;
      end
      checks++;
      if (nib_q[2] !== 5'h14 || nib_q[3] !== 5'h12) begin
        $display("FAIL data_b2b_nibs got %h %h want 14 12",
                 nib_q[2], nib_q[3]);
        failures++;
      end
    end
    checks++;
    if (stable_err != 0) begin
      $display("FAIL data_stable got %0d want 0", stable_err);
      failures++;
    end
  endtask

  task automatic test_long_wait();
    int acc1, acc2, tid, dt;
    bit ok1, ok2, ok3;
    logic late1, late2;
    @(negedge refclk);
    clear_log();
    send(1'b0, 1'b0, 8'h01, 100, acc1, ok1, late1);
    send(1'b1, 1'b1, 8'h42, 2000, acc2, ok2, late2);
    wait_idle(500, ok3, tid);
    checks++;
    if (!ok1 || !ok2 || !ok3 || nib_q.size() != 4) begin
      $display("FAIL long_count got ok=%0d%0d%0d n=%0d want 111/4",
               ok1, ok2, ok3, nib_q.size());
      failures++;
    end else begin
      dt = acc2 - fall_q[1];
      checks++;
      if (dt < LONG_US * US || dt > LONG_US * US + 10) begin
        $display("FAIL long_wait got %0d want %0d..%0d",
                 dt, LONG_US * US, LONG_US * US + 10);
        failures++;
      end
      checks++;
      if (nib_q[0] !== 5'h00 || nib_q[1] !== 5'h01 ||
          nib_q[2] !== 5'h14 || nib_q[3] !== 5'h12) begin
        $display("FAIL long_nibs got %h %h %h %h want 00 01 14 12",
                 nib_q[0], nib_q[1], nib_q[2], nib_q[3]);
        failures++;
      end
      checks++;
      if (late2 !== 1'b0) begin
        $display("FAIL b_ready_pulse got %b want 0", late2);
        failures++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit g [4];
    bit exp_g [4];
    int cnt, both, tid;
    bit ok;
`ifdef LCD_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    g = '{1'b0, 1'b0, 1'b0, 1'b0};
    cnt = 0;
    both = 0;
    @(negedge refclk);
    clear_log();
    a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h61;
    b_valid = 1'b1; b_rs = 1'b1; b_data = 8'h62;
    for (int n = 0; n < 4000 && cnt < 4; n++) begin
      #1;
      if (a_ready && b_ready) both++;
      if (a_ready === 1'b1) begin
        g[cnt] = 1'b0; cnt++;
      end else if (b_ready === 1'b1) begin
        g[cnt] = 1'b1; cnt++;
      end
      @(negedge refclk);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    wait_idle(500, ok, tid);
    checks++;
    if (cnt != 4 || both != 0 || !ok) begin
      $display("FAIL arb_count got %0d both=%0d want 4/0",
               cnt, both);
      failures++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (g[i] !== exp_g[i]) begin
        $display("FAIL arb_grant%0d got %0d want %0d",
                 i, g[i], exp_g[i]);
        failures++;
      end
    end
    checks++;
    if (nib_q.size() != 8) begin
      $display("FAIL arb_nib_count got %0d want 8", nib_q.size());
      failures++;
    end else if (nib_q[3] !== (exp_g[1] ? 5'h12 : 5'h11)) begin
      $display("FAIL arb_byte2 got %h want %h",
               nib_q[3], exp_g[1] ? 5'h12 : 5'h11);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    int acc, at, rs1;
    bit ok, ok2;
    logic late;
    @(negedge refclk);
    send(1'b0, 1'b1, 8'h55, 100, acc, ok, late);
    ok2 = 1'b0;
    for (int n = 0; n < 50 && !ok2; n++) begin
      #1;
      if (lcd_e === 1'b1) ok2 = 1'b1;
      else @(negedge refclk);
    end
    @(negedge refclk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || !ok2 || lcd_e !== 1'b0) begin
      $display("FAIL mid_rst_e got e=%b ok=%0d%0d want 0/11",
               lcd_e, ok, ok2);
      failures++;
    end
    checks++;
    if (init_done !== 1'b0 || busy !== 1'b1 || lcd_dq !== 4'h0) begin
      $display("FAIL mid_rst_flags got %b%b/%h want 01/0",
               init_done, busy, lcd_dq);
      failures++;
    end
    repeat (2) @(negedge refclk);
    clear_log();
    rst_n = 1'b1;
    wait_init(20000, ok, at);
    rs1 = 0;
    foreach (nib_q[i]) if (nib_q[i][4]) rs1++;
    checks++;
    if (!ok || nib_q.size() != 12 || rs1 != 0) begin
      $display("FAIL mid_rst_replay got ok=%0d n=%0d rs1=%0d want 1/12/0",
               ok, nib_q.size(), rs1);
      failures++;
    end else if (nib_q[0] !== 5'h03 || nib_q[11] !== 5'h06) begin
      $display("FAIL mid_rst_seq got %h..%h want 03..06",
               nib_q[0], nib_q[11]);
      failures++;
    end
  endtask

  task automatic test_b_during_init();
    int early, tid;
    bit ok, ok2;
    logic done_at;
    @(negedge refclk);
    rst_n = 1'b0;
    repeat (2) @(negedge refclk);
    clear_log();
    b_valid = 1'b1; b_rs = 1'b1; b_data = 8'h37;
    rst_n = 1'b1;
    early = 0;
    ok = 1'b0;
    done_at = 1'b0;
    for (int n = 0; n < 20000 && !ok; n++) begin
      #1;
      if (b_ready === 1'b1) begin
        if (init_done !== 1'b1) early++;
        done_at = init_done;
        ok = 1'b1;
      end
      @(negedge refclk);
    end
    b_valid = 1'b0;
    wait_idle(500, ok2, tid);
    checks++;
    if (!ok || early != 0 || done_at !== 1'b1) begin
      $display("FAIL b_init_gate got ok=%0d early=%0d done=%b want 1/0/1",
               ok, early, done_at);
      failures++;
    end
    checks++;
    if (!ok2 || nib_q.size() != 14) begin
      $display("FAIL b_init_count got %0d want 14", nib_q.size());
      failures++;
    end else if (nib_q[12] !== 5'h13 || nib_q[13] !== 5'h17) begin
      $display("FAIL b_init_byte got %h %h want 13 17",
               nib_q[12], nib_q[13]);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_write();
    test_long_wait();
    test_back_to_back();
    test_reset_mid();
    test_b_during_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
